// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB-first, repeated repeat_cnt+1 times.
// Define SEQGEN_GUARD_EN to insert GUARD_LEN idle cycles between consecutive frames.
module seq_pattern_gen #(
   parameter int unsigned      PAT_W       = 4,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1011,
   parameter int unsigned      CNT_W       = 4,
   parameter int unsigned      GUARD_LEN   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             use_default,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   output logic             x,
   output logic             valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int unsigned     BIT_W    = $clog2(PAT_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

`ifdef SEQGEN_GUARD_EN
   localparam int unsigned      GRD_W    = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
   localparam logic [GRD_W-1:0] LAST_GRD = GRD_W'(GUARD_LEN - 1);

   typedef enum logic [1:0] {StIdle = 2'd0, StSend = 2'd1, StGuard = 2'd2, StDone = 2'd3} state_e;
`else
   typedef enum logic [1:0] {StIdle = 2'd0, StSend = 2'd1, StDone = 2'd3} state_e;
`endif

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   // Frames remaining after the current one; holding frames-minus-one avoids any wrap.
   logic [CNT_W-1:0] rem_q, rem_d;
`ifdef SEQGEN_GUARD_EN
   logic [GRD_W-1:0] grd_q, grd_d;
`endif
   logic x_d, valid_d, frame_start_d, busy_d, done_d;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      rem_d   = rem_q;
`ifdef SEQGEN_GUARD_EN
      grd_d   = grd_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               pat_d   = use_default ? PAT_DEFAULT : pattern;
               shreg_d = pat_d;
               rem_d   = repeat_cnt;
               bit_d   = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            shreg_d = {shreg_q[PAT_W-2:0], shreg_q[PAT_W-1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
               bit_d = '0;
               if (rem_q != '0) begin
                  rem_d   = rem_q - CNT_W'(1);
                  shreg_d = pat_q;
`ifdef SEQGEN_GUARD_EN
                  grd_d   = '0;
                  state_d = StGuard;
`else
                  state_d = StSend;
`endif
               end else begin
                  state_d = StDone;
               end
            end
         end
`ifdef SEQGEN_GUARD_EN
         StGuard: begin
            grd_d = grd_q + GRD_W'(1);
            if (grd_q == LAST_GRD) begin
               state_d = StSend;
            end
         end
`endif
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are decoded from the next state so they can be registered without extra latency.
      x_d           = (state_d == StSend) & shreg_d[PAT_W-1];
      valid_d       = (state_d == StSend);
      frame_start_d = (state_d == StSend) && (bit_d == '0);
`ifdef SEQGEN_GUARD_EN
      busy_d        = (state_d == StSend) || (state_d == StGuard);
`else
      busy_d        = (state_d == StSend);
`endif
      done_d        = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         pat_q       <= '0;
         shreg_q     <= '0;
         bit_q       <= '0;
         rem_q       <= '0;
`ifdef SEQGEN_GUARD_EN
         grd_q       <= '0;
`endif
         x           <= 1'b0;
         valid       <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         shreg_q     <= shreg_d;
         bit_q       <= bit_d;
         rem_q       <= rem_d;
`ifdef SEQGEN_GUARD_EN
         grd_q       <= grd_d;
`endif
         x           <= x_d;
         valid       <= valid_d;
         frame_start <= frame_start_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern generator: latches a PAT_W-bit pattern on a start request and shifts it out MSB-first on a single-bit line, repeating it a programmable number of times. It is the transmit-side companion of the sequence detectors and drives their `x` input in system tests and loopback. Its default pattern, 1011, produces one detector hit per frame.

## Interface
Parameters:
- PAT_W, 4, pattern width in bits (2..16)
- PAT_DEFAULT, 4'b1011, pattern used when `use_default` is high at start
- CNT_W, 4, width of `repeat_cnt`
- GUARD_LEN, 2, guard-gap length in cycles (used only with SEQGEN_GUARD_EN; ≥1)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  transmit request; sampled only in IDLE
- use_default  in  1  at start: 1 selects PAT_DEFAULT, 0 selects `pattern`
- pattern  in  PAT_W  user pattern, latched at start
- repeat_cnt  in  CNT_W  number of frames minus one, latched at start
- x  out  1  serial data, registered
- valid  out  1  `x` carries a pattern bit this cycle
- frame_start  out  1  high during the first bit (MSB) of each frame
- busy  out  1  high in SEND and GUARD
- done  out  1  one-cycle pulse after the last bit of the last frame

## Operation
- States: IDLE, SEND, GUARD (only with the macro), DONE.
- IDLE:
  - Outputs x=0, valid=0, busy=0.
  - On start=1: latch the selected pattern into a shift register, latch frames = repeat_cnt+1 (range 1..2^CNT_W), clear the bit counter, go to SEND.
- SEND:
  - x = shreg[PAT_W-1]; valid=1; busy=1; frame_start=1 when the bit counter is 0.
  - Each cycle: rotate shreg left and increment the bit counter.
  - After bit PAT_W-1:
    - If frames remain: decrement the frame count, reload shreg from the latched pattern, go to SEND (or GUARD with the macro).
    - Otherwise go to DONE.
- GUARD: x=0, valid=0, busy=1 for GUARD_LEN cycles, then SEND with the bit counter at 0.
- DONE: done=1, busy=0, x=0, valid=0 for exactly one cycle, then IDLE. A start in DONE is ignored.
- Once busy, the block ignores start, pattern, use_default and repeat_cnt.
- The frame counter must not wrap: repeat_cnt = all-ones yields exactly 2^CNT_W frames.
- Unused state encodings go to IDLE with outputs 0.

## Timing
- Reset values: x=0, valid=0, frame_start=0, busy=0, done=0; state IDLE.
- Reset has priority over all events. Reset during SEND or GUARD aborts with no done pulse, and outputs are 0 from the next cycle.
- Latency: start sampled at edge k puts the MSB on `x` in cycle k+1.
- Without the macro, frames are back-to-back: the last bit of last frame is in cycle k+F·PAT_W and done is in cycle k+F·PAT_W+1.
- With the macro: done is in cycle k+F·PAT_W+(F−1)·GUARD_LEN+1.
- Earliest next accepted start: the cycle after done (IDLE).
- start held high continuously: a new transfer begins on the edge the block is in IDLE, so there is a one-cycle IDLE gap after DONE.

## Configuration
- SEQGEN_GUARD_EN defined:
  - GUARD state compiled in.
  - GUARD_LEN zero cycles (valid=0) are inserted between consecutive frames.
  - No guard after the last frame.
- SEQGEN_GUARD_EN undefined:
  - GUARD state and its counter are absent.
  - Frames are contiguous, so an overlapping downstream detector sees every frame.

## Test plan
- Reset then idle: reset=1 for 2 cycles, start=0 → x, valid, busy, done, frame_start all 0 throughout.
- Default single frame: use_default=1, repeat_cnt=0, start pulse at edge k → x=1,0,1,1 in cycles k+1..k+4; frame_start only at k+1; done at k+5 only.
- Repeats, no macro: user pattern 4'b1101, repeat_cnt=2 → x=110111011101 over 12 cycles with valid=1; frame_start at cycles 1, 5, 9; done at 13.
- Guard, macro on: default pattern, repeat_cnt=1, GUARD_LEN=2 → x=1011,00,1011 with valid=0 in the gap; done 11 cycles after start.
- Busy ignore: start pulses and pattern changes mid-SEND → stream unchanged, single done; saturation with repeat_cnt=4'hF → exactly 16 frames.
- Reset mid-frame: reset at the third bit of frame 2 → outputs 0 next cycle, no done; a following start transmits normally.
